// File: rtl/multicycle_ctrl_fsm.sv
// Multicycle MIPS-subset sequencer: one instruction per FETCH..WB walk, strobes decoded from state.
// Memory phases stall on mem_ready; a watchdog halts after MEM_TIMEOUT idle cycles (0 disables).
module multicycle_ctrl_fsm #(
  parameter int CNT_W       = 32,
  parameter int MEM_TIMEOUT = 255
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [5:0]       opcode,
  input  logic [5:0]       funct,
  input  logic             alu_zero,
  input  logic             mem_ready,
  output logic             ir_wr,
  output logic             pc_wr,
  output logic [1:0]       pc_src,
  output logic             reg_wr,
  output logic [1:0]       reg_dst,
  output logic [1:0]       wb_sel,
  output logic             alu_src,
  output logic [2:0]       alu_ctrl,
  output logic             mem_req,
  output logic             mem_we,
  output logic             halt,
  output logic [1:0]       halt_cause,
  output logic [2:0]       state,
  output logic [CNT_W-1:0] retired_count
);

  localparam int WAIT_W = (MEM_TIMEOUT < 2) ? 1 : $clog2(MEM_TIMEOUT + 1);

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_JAL   = 6'h03;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_XORI  = 6'h0e;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2b;
  localparam logic [5:0] FN_JR    = 6'h08;
  localparam logic [5:0] FN_ADD   = 6'h20;
  localparam logic [5:0] FN_SUB   = 6'h22;
  localparam logic [5:0] FN_SLT   = 6'h2a;

  localparam logic [1:0] PC_BR   = 2'd1;
  localparam logic [1:0] PC_JUMP = 2'd2;
  localparam logic [1:0] PC_RS   = 2'd3;
  localparam logic [1:0] DST_RT  = 2'd1;
  localparam logic [1:0] DST_R31 = 2'd2;
  localparam logic [1:0] WB_MEM  = 2'd1;
  localparam logic [1:0] WB_PC4  = 2'd2;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_XOR = 3'b010;
  localparam logic [2:0] ALU_SLT = 3'b011;

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4,
    S_HALT   = 3'd5
  } state_t;

  state_t            cur;
  state_t            nxt;
  logic [WAIT_W-1:0] wait_cnt;
  logic              timeout;

  logic is_r, is_j, is_jal, is_jr, is_beq, is_bne, is_addi, is_xori;
  logic is_lw, is_sw, is_add, is_sub, is_slt, legal;

  assign is_r    = (opcode == OP_RTYPE);
  assign is_j    = (opcode == OP_J);
  assign is_jal  = (opcode == OP_JAL);
  assign is_beq  = (opcode == OP_BEQ);
  assign is_bne  = (opcode == OP_BNE);
  assign is_addi = (opcode == OP_ADDI);
  assign is_xori = (opcode == OP_XORI);
  assign is_lw   = (opcode == OP_LW);
  assign is_sw   = (opcode == OP_SW);
  assign is_jr   = is_r && (funct == FN_JR);
  assign is_add  = is_r && (funct == FN_ADD);
  assign is_sub  = is_r && (funct == FN_SUB);
  assign is_slt  = is_r && (funct == FN_SLT);
  assign legal   = is_j | is_jal | is_jr | is_beq | is_bne | is_addi | is_xori |
                   is_lw | is_sw | is_add | is_sub | is_slt;

  // A ready arriving on the limit cycle wins over the timeout.
  assign timeout = (MEM_TIMEOUT != 0) && !mem_ready &&
                   (wait_cnt == WAIT_W'(MEM_TIMEOUT - 1));

  assign state = cur;
  assign halt  = (cur == S_HALT);

  always_comb begin
    nxt = cur;
    case (cur)
      S_FETCH: begin
        if (mem_ready)    nxt = S_DECODE;
        else if (timeout) nxt = S_HALT;
      end
      S_DECODE: begin
        if (!legal)                        nxt = S_HALT;
        else if (is_j || is_jal || is_jr)  nxt = S_FETCH;
        else                               nxt = S_EXEC;
      end
      S_EXEC: begin
        if (is_beq || is_bne)     nxt = S_FETCH;
        else if (is_lw || is_sw)  nxt = S_MEM;
        else                      nxt = S_WB;
      end
      S_MEM: begin
        if (mem_ready)    nxt = is_sw ? S_FETCH : S_WB;
        else if (timeout) nxt = S_HALT;
      end
      S_WB:    nxt = S_FETCH;
      default: nxt = S_HALT;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cur           <= S_FETCH;
      wait_cnt      <= '0;
      halt_cause    <= 2'd0;
      retired_count <= '0;
    end else begin
      cur <= nxt;
      if (nxt != cur)
        wait_cnt <= '0;
      else if ((cur == S_FETCH || cur == S_MEM) && !mem_ready && MEM_TIMEOUT != 0)
        wait_cnt <= wait_cnt + 1'b1;
      if (cur == S_DECODE && nxt == S_HALT)
        halt_cause <= 2'd1;
      else if ((cur == S_FETCH || cur == S_MEM) && nxt == S_HALT)
        halt_cause <= 2'd2;
      if (nxt == S_FETCH && cur inside {S_DECODE, S_EXEC, S_MEM, S_WB} &&
          retired_count != '1)
        retired_count <= retired_count + 1'b1;
    end
  end

  always_comb begin
    ir_wr    = 1'b0;
    pc_wr    = 1'b0;
    pc_src   = 2'd0;
    reg_wr   = 1'b0;
    reg_dst  = 2'd0;
    wb_sel   = 2'd0;
    alu_src  = 1'b0;
    alu_ctrl = 3'b000;
    mem_req  = 1'b0;
    mem_we   = 1'b0;
    if (rst_n) begin
      case (cur)
        S_FETCH: begin
          mem_req = 1'b1;
          if (mem_ready) begin
            ir_wr = 1'b1;
            pc_wr = 1'b1;
          end
        end
        S_DECODE: begin
          if (is_j || is_jal) begin
            pc_wr  = 1'b1;
            pc_src = PC_JUMP;
          end
          if (is_jal) begin
            reg_wr  = 1'b1;
            reg_dst = DST_R31;
            wb_sel  = WB_PC4;
          end
          if (is_jr) begin
            pc_wr  = 1'b1;
            pc_src = PC_RS;
          end
        end
        S_EXEC: begin
          if (is_lw || is_sw || is_addi) begin
            alu_src = 1'b1;
          end else if (is_xori) begin
            alu_src  = 1'b1;
            alu_ctrl = ALU_XOR;
          end else if (is_sub) begin
            alu_ctrl = ALU_SUB;
          end else if (is_slt) begin
            alu_ctrl = ALU_SLT;
          end else if (is_beq || is_bne) begin
            alu_ctrl = ALU_XOR;
          end
          // Branch compares by xor: zero means the operands matched.
          if (is_beq || is_bne) begin
            pc_src = PC_BR;
            pc_wr  = is_beq ? alu_zero : !alu_zero;
          end
        end
        S_MEM: begin
          alu_src = 1'b1;
          mem_req = 1'b1;
          mem_we  = is_sw;
        end
        S_WB: begin
          reg_wr = 1'b1;
          if (is_lw) begin
            reg_dst = DST_RT;
            wb_sel  = WB_MEM;
          end else if (is_addi || is_xori) begin
            reg_dst = DST_RT;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_multicycle_ctrl_fsm.sv
// Bench for multicycle_ctrl_fsm: directed vector table, then random instruction streams vs. a per-instruction model.
module tb_multicycle_ctrl_fsm;

  localparam int TMO = 4;
  localparam int CW  = 4;
  localparam int CMAX = (1 << CW) - 1;

  logic          clk = 1'b0;
  logic          rst_n, alu_zero, mem_ready;
  logic [5:0]    opcode, funct;
  logic          ir_wr, pc_wr, reg_wr, alu_src, mem_req, mem_we, halt;
  logic [1:0]    pc_src, reg_dst, wb_sel, halt_cause;
  logic [2:0]    alu_ctrl, state;
  logic [CW-1:0] retired_count;

  always #5 clk = ~clk;

  multicycle_ctrl_fsm #(.CNT_W(CW), .MEM_TIMEOUT(TMO)) dut (
    .clk(clk), .rst_n(rst_n), .opcode(opcode), .funct(funct),
    .alu_zero(alu_zero), .mem_ready(mem_ready),
    .ir_wr(ir_wr), .pc_wr(pc_wr), .pc_src(pc_src), .reg_wr(reg_wr),
    .reg_dst(reg_dst), .wb_sel(wb_sel), .alu_src(alu_src), .alu_ctrl(alu_ctrl),
    .mem_req(mem_req), .mem_we(mem_we), .halt(halt), .halt_cause(halt_cause),
    .state(state), .retired_count(retired_count)
  );

  typedef struct {
    logic          rst_n;
    logic [5:0]    op;
    logic [5:0]    fn;
    logic          z;
    logic          rdy;
    logic          chk;
    logic [2:0]    st;
    logic [14:0]   strb;
    logic          hlt;
    logic [1:0]    cause;
    logic [CW-1:0] cnt;
  } vec_t;

  int   n_cmp = 0;
  int   n_bad = 0;
  vec_t tbl[$];
  vec_t q[$];

  // Strobe word order: ir_wr pc_wr pc_src reg_wr reg_dst wb_sel alu_src alu_ctrl mem_req mem_we
  function automatic logic [14:0] pk(input int ir, pcw, pcs, rw, rd, wb, as, ac, mr, mw);
    logic [31:0] a, b, c, d, e, f, g, h, i, j;
    a = ir; b = pcw; c = pcs; d = rw; e = rd; f = wb; g = as; h = ac; i = mr; j = mw;
    return {a[0], b[0], c[1:0], d[0], e[1:0], f[1:0], g[0], h[2:0], i[0], j[0]};
  endfunction

  function automatic vec_t mk(input int rst, op, fn, z, rdy, st, input logic [14:0] strb,
                              input int hlt, cause, cnt);
    vec_t v;
    logic [31:0] t;
    t = rst;   v.rst_n = t[0];  v.chk = t[0];
    t = op;    v.op    = t[5:0];
    t = fn;    v.fn    = t[5:0];
    t = z;     v.z     = t[0];
    t = rdy;   v.rdy   = t[0];
    t = st;    v.st    = t[2:0];
    v.strb = strb;
    t = hlt;   v.hlt   = t[0];
    t = cause; v.cause = t[1:0];
    t = cnt;   v.cnt   = t[CW-1:0];
    return v;
  endfunction

  function automatic int rnd_bit();
    return int'($urandom_range(0, 1));
  endfunction

  task automatic apply(input vec_t v, input string tag);
    logic [14:0] gs;
    rst_n = v.rst_n; opcode = v.op; funct = v.fn; alu_zero = v.z; mem_ready = v.rdy;
    @(negedge clk);
    gs = {ir_wr, pc_wr, pc_src, reg_wr, reg_dst, wb_sel, alu_src, alu_ctrl, mem_req, mem_we};
    n_cmp++;
    if (v.chk) begin
      if ({state, gs, halt, halt_cause, retired_count} !== {v.st, v.strb, v.hlt, v.cause, v.cnt}) begin
        n_bad++;
        $display("FAIL %s: got st=%0d strb=%h halt=%0d cause=%0d cnt=%0d, expected st=%0d strb=%h halt=%0d cause=%0d cnt=%0d",
                 tag, state, gs, halt, halt_cause, retired_count, v.st, v.strb, v.hlt, v.cause, v.cnt);
      end
    end else if (gs !== v.strb) begin
      n_bad++;
      $display("FAIL %s (reset): got strb=%h, expected strb=%h", tag, gs, v.strb);
    end
    @(posedge clk);
    #1;
  endtask

  function automatic int bump(input int c);
    return (c < CMAX) ? c + 1 : c;
  endfunction

  task automatic halt_tail(input int op, fn, z, cause, cnt);
    repeat (2) q.push_back(mk(1, op, fn, z, rnd_bit(), 5, 15'h0, 1, cause, cnt));
  endtask

  // Expected cycle-by-cycle trace of one instruction, built from its class and memory latencies.
  task automatic gen(input int op, fn, z, flat, mlat, inout int cnt, output bit halted);
    bit r_t, lw, sw, br, jmp, legal;
    int ac, as;
    logic [14:0] s;
    r_t   = (op == 0);
    lw    = (op == 'h23);
    sw    = (op == 'h2b);
    br    = (op == 4) || (op == 5);
    jmp   = (op == 2) || (op == 3) || (r_t && fn == 8);
    legal = lw || sw || br || jmp || op == 8 || op == 'h0e ||
            (r_t && (fn == 'h20 || fn == 'h22 || fn == 'h2a));
    halted = 1'b0;
    for (int i = 0; i < flat && i < TMO; i++)
      q.push_back(mk(1, op, fn, z, 0, 0, pk(0,0,0,0,0,0,0,0,1,0), 0, 0, cnt));
    if (flat >= TMO) begin halt_tail(op, fn, z, 2, cnt); halted = 1'b1; return; end
    q.push_back(mk(1, op, fn, z, 1, 0, pk(1,1,0,0,0,0,0,0,1,0), 0, 0, cnt));
    if (!legal) begin
      q.push_back(mk(1, op, fn, z, rnd_bit(), 1, 15'h0, 0, 0, cnt));
      halt_tail(op, fn, z, 1, cnt);
      halted = 1'b1;
      return;
    end
    if (jmp) begin
      if (op == 2)      s = pk(0,1,2,0,0,0,0,0,0,0);
      else if (op == 3) s = pk(0,1,2,1,2,2,0,0,0,0);
      else              s = pk(0,1,3,0,0,0,0,0,0,0);
      q.push_back(mk(1, op, fn, z, rnd_bit(), 1, s, 0, 0, cnt));
      cnt = bump(cnt);
      return;
    end
    q.push_back(mk(1, op, fn, z, rnd_bit(), 1, 15'h0, 0, 0, cnt));
    if (lw || sw || op == 8) begin ac = 0; as = 1; end
    else if (op == 'h0e)     begin ac = 2; as = 1; end
    else if (br)             begin ac = 2; as = 0; end
    else if (fn == 'h20)     begin ac = 0; as = 0; end
    else if (fn == 'h22)     begin ac = 1; as = 0; end
    else                     begin ac = 3; as = 0; end
    if (br) begin
      q.push_back(mk(1, op, fn, z, rnd_bit(), 2,
                     pk(0, (op == 4) ? z : 1 - z, 1, 0, 0, 0, as, ac, 0, 0), 0, 0, cnt));
      cnt = bump(cnt);
      return;
    end
    q.push_back(mk(1, op, fn, z, rnd_bit(), 2, pk(0,0,0,0,0,0,as,ac,0,0), 0, 0, cnt));
    if (lw || sw) begin
      s = pk(0,0,0,0,0,0,1,0,1,int'(sw));
      for (int i = 0; i < mlat && i < TMO; i++)
        q.push_back(mk(1, op, fn, z, 0, 3, s, 0, 0, cnt));
      if (mlat >= TMO) begin halt_tail(op, fn, z, 2, cnt); halted = 1'b1; return; end
      q.push_back(mk(1, op, fn, z, 1, 3, s, 0, 0, cnt));
      if (sw) begin cnt = bump(cnt); return; end
    end
    q.push_back(mk(1, op, fn, z, rnd_bit(), 4,
                   pk(0,0,0,1, r_t ? 0 : 1, int'(lw), 0,0,0,0), 0, 0, cnt));
    cnt = bump(cnt);
  endtask

  task automatic flush(input string tag);
    int k = 0;
    while (q.size() > 0) begin
      apply(q.pop_front(), $sformatf("%s.%0d", tag, k));
      k++;
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation did not finish, expected finish");
    $fatal(1);
  end

  initial begin
    logic [14:0] f_ok, f_wait, none, ex_lw, mem_lw;
    logic [5:0]  ops [12];
    logic [5:0]  fns [5];
    int  cnt, op, fn, flat, mlat;
    bit  halted;

    f_ok   = pk(1,1,0,0,0,0,0,0,1,0);
    f_wait = pk(0,0,0,0,0,0,0,0,1,0);
    none   = 15'h0;
    ex_lw  = pk(0,0,0,0,0,0,1,0,0,0);
    mem_lw = pk(0,0,0,0,0,0,1,0,1,0);
    ops = '{6'h23, 6'h2b, 6'h02, 6'h03, 6'h04, 6'h05, 6'h08, 6'h0e, 6'h00, 6'h00, 6'h00, 6'h00};
    fns = '{6'h20, 6'h22, 6'h2a, 6'h08, 6'h15};

    rst_n = 1'b0; opcode = '0; funct = '0; alu_zero = 1'b0; mem_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;

    // Directed table: ADDI, branches, JAL/JR, illegal halt, fetch timeout, reset mid-MEM.
    tbl.push_back(mk(0, 0, 0, 0, 1, 0, none, 0, 0, 0));
    tbl.push_back(mk(1, 8, 5, 0, 1, 0, f_ok, 0, 0, 0));
    tbl.push_back(mk(1, 8, 5, 0, 1, 1, none, 0, 0, 0));
    tbl.push_back(mk(1, 8, 5, 0, 1, 2, ex_lw, 0, 0, 0));
    tbl.push_back(mk(1, 8, 5, 0, 1, 4, pk(0,0,0,1,1,0,0,0,0,0), 0, 0, 0));
    tbl.push_back(mk(1, 4, 0, 1, 1, 0, f_ok, 0, 0, 1));
    tbl.push_back(mk(1, 4, 0, 1, 1, 1, none, 0, 0, 1));
    tbl.push_back(mk(1, 4, 0, 1, 1, 2, pk(0,1,1,0,0,0,0,2,0,0), 0, 0, 1));
    tbl.push_back(mk(1, 4, 0, 0, 1, 0, f_ok, 0, 0, 2));
    tbl.push_back(mk(1, 4, 0, 0, 1, 1, none, 0, 0, 2));
    tbl.push_back(mk(1, 4, 0, 0, 1, 2, pk(0,0,1,0,0,0,0,2,0,0), 0, 0, 2));
    tbl.push_back(mk(1, 5, 0, 1, 1, 0, f_ok, 0, 0, 3));
    tbl.push_back(mk(1, 5, 0, 1, 1, 1, none, 0, 0, 3));
    tbl.push_back(mk(1, 5, 0, 1, 1, 2, pk(0,0,1,0,0,0,0,2,0,0), 0, 0, 3));
    tbl.push_back(mk(1, 5, 0, 0, 1, 0, f_ok, 0, 0, 4));
    tbl.push_back(mk(1, 5, 0, 0, 1, 1, none, 0, 0, 4));
    tbl.push_back(mk(1, 5, 0, 0, 1, 2, pk(0,1,1,0,0,0,0,2,0,0), 0, 0, 4));
    tbl.push_back(mk(1, 3, 0, 0, 1, 0, f_ok, 0, 0, 5));
    tbl.push_back(mk(1, 3, 0, 0, 1, 1, pk(0,1,2,1,2,2,0,0,0,0), 0, 0, 5));
    tbl.push_back(mk(1, 0, 8, 0, 1, 0, f_ok, 0, 0, 6));
    tbl.push_back(mk(1, 0, 8, 0, 1, 1, pk(0,1,3,0,0,0,0,0,0,0), 0, 0, 6));
    tbl.push_back(mk(1, 'h3f, 0, 0, 1, 0, f_ok, 0, 0, 7));
    tbl.push_back(mk(1, 'h3f, 0, 0, 1, 1, none, 0, 0, 7));
    tbl.push_back(mk(1, 'h3f, 0, 0, 1, 5, none, 1, 1, 7));
    tbl.push_back(mk(1, 'h3f, 0, 0, 0, 5, none, 1, 1, 7));
    tbl.push_back(mk(1, 'h3f, 0, 0, 1, 5, none, 1, 1, 7));
    tbl.push_back(mk(0, 'h3f, 0, 0, 1, 0, none, 0, 0, 0));
    for (int i = 0; i < 4; i++) tbl.push_back(mk(1, 8, 0, 0, 0, 0, f_wait, 0, 0, 0));
    tbl.push_back(mk(1, 8, 0, 0, 0, 5, none, 1, 2, 0));
    tbl.push_back(mk(1, 8, 0, 0, 1, 5, none, 1, 2, 0));
    tbl.push_back(mk(0, 'h23, 0, 0, 0, 0, none, 0, 0, 0));
    for (int i = 0; i < 3; i++) tbl.push_back(mk(1, 'h23, 0, 0, 0, 0, f_wait, 0, 0, 0));
    tbl.push_back(mk(1, 'h23, 0, 0, 1, 0, f_ok, 0, 0, 0));
    tbl.push_back(mk(1, 'h23, 0, 0, 0, 1, none, 0, 0, 0));
    tbl.push_back(mk(1, 'h23, 0, 0, 0, 2, ex_lw, 0, 0, 0));
    tbl.push_back(mk(1, 'h23, 0, 0, 0, 3, mem_lw, 0, 0, 0));
    tbl.push_back(mk(0, 'h23, 0, 0, 1, 0, none, 0, 0, 0));
    tbl.push_back(mk(1, 'h23, 0, 0, 0, 0, f_wait, 0, 0, 0));
    for (int i = 0; i < tbl.size(); i++) apply(tbl[i], $sformatf("dir%0d", i));

    // LW with a 3-cycle memory stall, SW, then enough jumps to saturate the counter.
    q.push_back(mk(0, 0, 0, 0, 0, 0, none, 0, 0, 0));
    cnt = 0;
    gen('h23, 0, 0, 0, 3, cnt, halted);
    gen('h2b, 0, 0, 1, 2, cnt, halted);
    for (int i = 0; i < 18; i++) gen(2, 0, 0, 0, 0, cnt, halted);
    flush("seq");

    for (int n = 0; n < 300; n++) begin
      op = ($urandom_range(0, 19) == 0) ? int'($urandom_range(0, 63)) : int'(ops[$urandom_range(0, 11)]);
      fn = (op == 0) ? int'(fns[$urandom_range(0, 4)]) : int'($urandom_range(0, 63));
      flat = ($urandom_range(0, 14) == 0) ? TMO : int'($urandom_range(0, TMO - 1));
      mlat = ($urandom_range(0, 14) == 0) ? TMO + 1 : int'($urandom_range(0, TMO - 1));
      gen(op, fn, rnd_bit(), flat, mlat, cnt, halted);
      if (halted) begin
        q.push_back(mk(0, op, fn, 0, rnd_bit(), 0, none, 0, 0, 0));
        cnt = 0;
      end
      flush($sformatf("rnd%0d", n));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
